// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low glyphs
// (bit order g,f,e,d,c,b,a), page encodings and scan FSM states.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_P     = 7'h0C;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_UNDER = 7'h77;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        PAGE_HH = 2'd0,
        PAGE_MM = 2'd1,
        PAGE_SS = 2'd2
    } page_t;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_t;

    // Pages cycle hours -> minutes -> seconds -> hours.
    function automatic page_t next_page(input page_t p);
        case (p)
            PAGE_HH: return PAGE_MM;
            PAGE_MM: return PAGE_SS;
            default: return PAGE_HH;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal
// nibbles show 'E' so corrupted counter values are visible on the display.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        case (nibble)
            4'd0:    seg_n = GLYPH_0;
            4'd1:    seg_n = GLYPH_1;
            4'd2:    seg_n = GLYPH_2;
            4'd3:    seg_n = GLYPH_3;
            4'd4:    seg_n = GLYPH_4;
            4'd5:    seg_n = GLYPH_5;
            4'd6:    seg_n = GLYPH_6;
            4'd7:    seg_n = GLYPH_7;
            4'd8:    seg_n = GLYPH_8;
            4'd9:    seg_n = GLYPH_9;
            default: seg_n = GLYPH_E;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Three-digit multiplexed display of BCD time, one page (hh/mm/ss) at a time.
// Optional feature macro: CLOCK_DISPLAY_BLINK_EN (blinking dp seconds indicator).
module clock_display_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int PAGE_SEC = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       page_next,
    input  logic       pm,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    output logic [7:0] seg_n,
    output logic [2:0] an_n,
    output logic [1:0] page
);

    // DIV must be at least 4 for the blank/drive split to make sense.
    localparam int DIV     = CLK_HZ / SCAN_HZ;
    localparam int PRESC_W = $clog2(DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 2);
    localparam int PSEC_W  = (PAGE_SEC > 1) ? $clog2(PAGE_SEC) : 1;
    localparam logic [PSEC_W-1:0] PSEC_LAST = PSEC_W'((PAGE_SEC > 0) ? PAGE_SEC - 1 : 0);
    localparam bit AUTO_EN = (PAGE_SEC != 0);

    scan_state_t        state_q, state_d;
    logic [1:0]         digit_q, digit_d;
    logic [PRESC_W-1:0] presc_q, presc_d;

    page_t              page_q;
    logic [PSEC_W-1:0]  sec_cnt_q;
    logic               auto_adv;

    logic [7:0]         snap_hh, snap_mm, snap_ss;
    logic               snap_pm;
    page_t              snap_page;
    logic               snap_en;

    logic [7:0]         field;
    logic [3:0]         nibble;
    logic [6:0]         dec_seg;
    logic [6:0]         digit_glyph;
    logic               dp_n;
    logic [7:0]         seg_d;
    logic [2:0]         an_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN_BLANK;
            digit_q <= 2'd2;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            presc_q <= presc_d;
        end
    end

    // One BLANK cycle, then DIV-1 DRIVE cycles; the digit steps as we leave DRIVE.
    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        presc_d = presc_q;
        case (state_q)
            SCAN_BLANK: begin
                state_d = SCAN_DRIVE;
                presc_d = '0;
            end
            SCAN_DRIVE: begin
                if (presc_q == PRESC_LAST) begin
                    state_d = SCAN_BLANK;
                    presc_d = '0;
                    digit_d = (digit_q == 2'd0) ? 2'd2 : digit_q - 2'd1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    assign auto_adv = AUTO_EN && sec_tick && (sec_cnt_q == PSEC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            page_q    <= PAGE_HH;
            sec_cnt_q <= '0;
        end else if (page_next || auto_adv) begin
            page_q    <= next_page(page_q);
            sec_cnt_q <= '0;
        end else if (sec_tick && AUTO_EN) begin
            sec_cnt_q <= sec_cnt_q + 1'b1;
        end
    end

    // Latching once per frame keeps all three digits consistent across a rollover.
    assign snap_en = (state_q == SCAN_BLANK) && (digit_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_hh   <= '0;
            snap_mm   <= '0;
            snap_ss   <= '0;
            snap_pm   <= 1'b0;
            snap_page <= PAGE_HH;
        end else if (snap_en) begin
            snap_hh   <= hh;
            snap_mm   <= mm;
            snap_ss   <= ss;
            snap_pm   <= pm;
            snap_page <= page_q;
        end
    end

`ifdef CLOCK_DISPLAY_BLINK_EN
    logic blink_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else if (sec_tick) begin
            blink_q <= ~blink_q;
        end
    end
`endif

    always_comb begin
        field = snap_ss;
        case (snap_page)
            PAGE_HH: field = snap_hh;
            PAGE_MM: field = snap_mm;
            default: field = snap_ss;
        endcase
        nibble = (digit_q == 2'd1) ? field[7:4] : field[3:0];
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .seg_n  (dec_seg)
    );

    // Digit 2 carries the page glyph; a leading zero hour is suppressed.
    always_comb begin
        digit_glyph = dec_seg;
        dp_n        = 1'b1;
        if (digit_q == 2'd2) begin
            case (snap_page)
                PAGE_HH: digit_glyph = snap_pm ? GLYPH_P : GLYPH_A;
                PAGE_MM: digit_glyph = GLYPH_DASH;
                default: digit_glyph = GLYPH_UNDER;
            endcase
        end else if (digit_q == 2'd1 && snap_page == PAGE_HH && field[7:4] == 4'd0) begin
            digit_glyph = GLYPH_BLANK;
        end
`ifdef CLOCK_DISPLAY_BLINK_EN
        if (digit_q == 2'd1 && snap_page != PAGE_SS && blink_q) begin
            dp_n = 1'b0;
        end
`endif
        if (state_q == SCAN_DRIVE) begin
            seg_d = {dp_n, digit_glyph};
            an_d  = ~(3'b001 << digit_q);
        end else begin
            seg_d = 8'hFF;
            an_d  = 3'b111;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n <= 8'hFF;
            an_n  <= 3'b111;
        end else begin
            seg_n <= seg_d;
            an_n  <= an_d;
        end
    end

    assign page = page_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan with DIV=10 and PAGE_SEC=3; frames are
// queued as stimulus is applied and compared as each digit comes up on the display.
module tb_clock_display_scan;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       sec_tick  = 1'b0;
    logic       page_next = 1'b0;
    logic       pm        = 1'b0;
    logic [7:0] hh        = 8'h00;
    logic [7:0] mm        = 8'h00;
    logic [7:0] ss        = 8'h00;
    logic [7:0] seg_n;
    logic [2:0] an_n;
    logic [1:0] page;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        bit         dp_blink;
    } digit_exp_t;

    digit_exp_t exp_q[$];
    int         assert_count = 0;
    int         fail_count   = 0;
    int         model_page   = 0;
    bit         monitor_en   = 1'b1;

    clock_display_scan #(
        .CLK_HZ   (1000),
        .SCAN_HZ  (100),
        .PAGE_SEC (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sec_tick  (sec_tick),
        .page_next (page_next),
        .pm        (pm),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .seg_n     (seg_n),
        .an_n      (an_n),
        .page      (page)
    );

    always #5 clk = ~clk;

`ifdef CLOCK_DISPLAY_BLINK_EN
    logic blink_ref;

    always @(posedge clk) begin
        if (reset) blink_ref <= 1'b0;
        else if (sec_tick) blink_ref <= ~blink_ref;
    end
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] glyphOf(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit s, input bit n);
        sec_tick  = s;
        page_next = n;
        tick(1);
        sec_tick  = 1'b0;
        page_next = 1'b0;
    endtask

    // Drive the time inputs just before a frame snapshot and queue the frame it should produce.
    task automatic applyStimulus(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        logic [7:0] f;
        digit_exp_t e;
        hh = h;
        mm = m;
        ss = s;
        pm = p;
        f = (model_page == 0) ? h : (model_page == 1) ? m : s;
        e.an       = 3'b011;
        e.dp_blink = 1'b0;
        e.seg      = (model_page == 0) ? (p ? 7'h0C : 7'h08) : (model_page == 1) ? 7'h3F : 7'h77;
        exp_q.push_back(e);
        e.an       = 3'b101;
        e.dp_blink = (model_page != 2);
        e.seg      = (model_page == 0 && f[7:4] == 4'd0) ? 7'h7F : glyphOf(f[7:4]);
        exp_q.push_back(e);
        e.an       = 3'b110;
        e.dp_blink = 1'b0;
        e.seg      = glyphOf(f[3:0]);
        exp_q.push_back(e);
    endtask

    // Digit monitor: checks blank separation and period, and pops the scoreboard per digit.
    initial begin
        logic [2:0] prev_an = 3'b111;
        int         since_start = 0;
        bit         have_start = 1'b0;
        digit_exp_t e;
        logic       dp_exp;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_start  = 1'b0;
                since_start = 0;
            end else if (monitor_en) begin
                since_start++;
                if (prev_an != 3'b111 && an_n != 3'b111 && an_n != prev_an)
                    checkOutput("blank_gap", an_n, prev_an);
                if (prev_an == 3'b111 && an_n != 3'b111) begin
                    checkOutput("an_onehot", (an_n == 3'b011 || an_n == 3'b101 || an_n == 3'b110), 1);
                    if (have_start) checkOutput("digit_period", since_start, 10);
                    have_start  = 1'b1;
                    since_start = 0;
                    if (exp_q.size() == 0) begin
                        checkOutput("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        dp_exp = 1'b1;
`ifdef CLOCK_DISPLAY_BLINK_EN
                        if (e.dp_blink) dp_exp = ~blink_ref;
`endif
                        checkOutput($sformatf("digit_an%b", e.an), {an_n, seg_n}, {e.an, dp_exp, e.seg});
                    end
                end
            end
            prev_an = an_n;
        end
    end

    initial begin
        hh = 8'h07; mm = 8'h3C; ss = 8'h59; pm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("reset_an", an_n, 3'b111);
            checkOutput("reset_seg", seg_n, 8'hFF);
        end
        checkOutput("reset_page", page, 0);
        reset = 1'b0;

        // Frame 0: hours page, PM, leading zero blanked; three ticks rotate the page.
        applyStimulus(8'h07, 8'h3C, 8'h59, 1'b1);
        tick(1);
        checkOutput("release_an", an_n, 3'b111);
        checkOutput("release_seg", seg_n, 8'hFF);
        tick(1);
        checkOutput("first_digit_an", an_n, 3'b011);
        tick(2);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        tick(2);
        checkOutput("page_before_third_tick", page, 0);
        pulse(1'b1, 1'b0);
        checkOutput("page_auto_advance", page, 1);
        model_page = 1;
        tick(19);

        // Frame 1: minutes page with invalid BCD; page_next coincides with the third tick.
        applyStimulus(8'h07, 8'h3C, 8'h59, 1'b1);
        tick(4);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b1);
        checkOutput("page_overlap_once", page, 2);
        model_page = 2;
        tick(3);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        checkOutput("page_count_restart", page, 2);
        tick(12);

        // Frame 2: seconds change mid-frame must not tear the displayed value.
        applyStimulus(8'h07, 8'h3C, 8'h59, 1'b1);
        tick(14);
        checkOutput("tear_digit1_active", an_n, 3'b101);
        ss = 8'h00;
        tick(16);

        // Frame 3: the new seconds value appears; count resumes and page_next clears it.
        applyStimulus(8'h07, 8'h3C, 8'h00, 1'b1);
        tick(4);
        pulse(1'b1, 1'b0);
        checkOutput("page_third_after_restart", page, 0);
        model_page = 0;
        tick(2);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b0, 1'b1);
        checkOutput("page_next_only", page, 1);
        model_page = 1;
        tick(3);
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        checkOutput("page_next_clears_count", page, 1);
        tick(12);

        // Frame 4: minutes page, then rotate back around to hours.
        applyStimulus(8'h23, 8'h45, 8'h00, 1'b0);
        tick(4);
        pulse(1'b1, 1'b0);
        checkOutput("page_auto_to_ss", page, 2);
        model_page = 2;
        tick(9);
        pulse(1'b0, 1'b1);
        checkOutput("page_wrap_to_hh", page, 0);
        model_page = 0;
        tick(15);

        // Frame 5: hours page, AM, nonzero tens digit shown.
        applyStimulus(8'h12, 8'h45, 8'h00, 1'b0);
        tick(14);
        pulse(1'b0, 1'b1);
        checkOutput("page_next_to_mm", page, 1);
        model_page = 1;
        tick(15);

        monitor_en = 1'b0;
        checkOutput("sb_drained", exp_q.size(), 0);

        // Reset asserted in the middle of a driven digit.
        tick(5);
        checkOutput("pre_reset_driving", an_n, 3'b011);
        reset = 1'b1;
        tick(1);
        checkOutput("midreset_an", an_n, 3'b111);
        checkOutput("midreset_seg", seg_n, 8'hFF);
        checkOutput("midreset_page", page, 0);
        tick(2);
        reset = 1'b0;
        tick(1);
        checkOutput("rerelease_an", an_n, 3'b111);
        tick(1);
        checkOutput("rerelease_first_digit", an_n, 3'b011);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/clock_display_scan.md
# clock_display_scan

Multiplexed seven-segment driver for the 3-digit display, sitting directly downstream of the clock counter. Takes BCD hours/minutes/seconds plus the PM flag. Shows one page at a time on the three digits: hours with an A/P indicator, then minutes, then seconds. Pages rotate on a seconds count or on an external request. Scans the digits with per-digit blanking so that no ghosting appears.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `SCAN_HZ`, 1000, per-digit refresh rate. Derived `DIV = CLK_HZ/SCAN_HZ`, which must be ≥ 4.
- `PAGE_SEC`, 3, number of `sec_tick` pulses per automatic page advance. 0 disables auto-rotation.
- `clk`  in  1  the single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `sec_tick`  in  1  one-cycle pulse per second, the same enable that drives the clock counter.
- `page_next`  in  1  one-cycle pulse; advances the page.
- `pm`  in  1  PM flag.
- `hh`, `mm`, `ss`  in  8 each  packed BCD, tens in [7:4] and units in [3:0].
- `seg_n`  out  8  active-low segments: [6:0] = g,f,e,d,c,b,a and [7] = dp.
- `an_n`  out  3  active-low digit enables; [2] is the leftmost digit.
- `page`  out  2  current page: 0 = hours, 1 = minutes, 2 = seconds.

## Operation
- **Reset values.**
  - Outputs: `seg_n`=8'hFF, `an_n`=3'b111, `page`=0.
  - Internal state: digit index=2, state=BLANK, prescaler=0, page-second count=0, snapshot=0, blink=0.
- **Scan FSM, two states.**
  - BLANK lasts 1 cycle. It drives `an_n`=111 and `seg_n`=FF.
  - DRIVE lasts DIV-1 cycles and enables the current digit.
  - DRIVE→BLANK occurs at prescaler terminal count. On that transition the digit index steps 2→1→0→2.
- **Frame snapshot.** In each BLANK cycle whose digit index is 2, `hh`, `mm`, `ss`, `pm` and `page` are latched. All three digits of a frame show the same snapshot, so there is no tearing across a counter rollover.
- **Digit content.**
  - Digits 1 and 0 show the tens and units nibbles of the page's field: `hh`, `mm` or `ss`.
  - Digit 2 is a page glyph:
    - page 0: 'P' (a,b,e,f,g) if PM, else 'A' (a,b,c,e,f,g).
    - page 1: '-' (g).
    - page 2: '_' (d).
  - On page 0 only, an hours tens nibble of 0 is blanked.
- **Decoding.**
  - Nibbles 0–9 use the standard patterns.
  - Nibbles A–F display 'E' (a,d,e,f,g) as an error indication.
  - dp is off, except as described under Configuration.
- **Page rotation.**
  - With PAGE_SEC≠0, each `sec_tick` increments the count. When the count reaches PAGE_SEC, the page advances 0→1→2→0 and the count clears.
  - `page_next` advances the page and clears the count.
  - If `page_next` and an auto-advance occur in the same cycle, the page advances once only.
- **Reset mid-frame.** On the next edge, all state and outputs return to their reset values, with no partial digit.

## Timing
- **Outputs.** `seg_n` and `an_n` are registered and reflect the FSM state of the previous cycle.
- **First frame.** The first clock after reset deasserts is BLANK for digit 2. `an_n`=011 appears one cycle after that.
- **Periods.** Digit period is exactly DIV cycles; frame period is 3·DIV cycles.
- **`page` output.** Updates the cycle after the advance event. The displayed content follows at the next frame snapshot, so display latency is ≤ 3·DIV+1 cycles.
- **Digit enables.** Never more than one `an_n` bit is low. Every change of active digit is separated by one all-high cycle.

## Configuration
- `CLOCK_DISPLAY_BLINK_EN`:
  - When defined, a blink flop toggles on each `sec_tick`. Digit 1's dp is lit while blink=1 on pages 0 and 1, forming a seconds indicator between fields.
  - When undefined, there is no blink flop and dp is always off (`seg_n[7]`=1).

## Structure
- **Package `seg7_pkg`.**
  - Glyph constants: digits 0–9, GLYPH_A, GLYPH_P, GLYPH_DASH, GLYPH_UNDER, GLYPH_E, GLYPH_BLANK.
  - Page encodings: PAGE_HH, PAGE_MM, PAGE_SS.
  - Scan state encodings.
- **Sub-module `seg7_decode`.** Combinational, 4-bit nibble to 7 active-low segments, including the 'E' mapping for A–F. Instantiated once on the muxed nibble.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=100 (DIV=10) and PAGE_SEC=3.
- **Reset.** Hold reset 5 cycles, then release. Require:
  - `an_n`=111 and `seg_n`=FF during reset and for the first cycle after release.
  - `an_n`=011 on the next cycle.
  - Subsequent digit periods of exactly 10 cycles with one blank cycle each.
- **Page 0 content.** hh=8'h07, pm=1, page 0. Require:
  - digit 2 = 'P'.
  - digit 1 blank (FF).
  - digit 0 = '7' (seg_n=8'hF8).
- **Auto-rotation and overlap.**
  - Three `sec_tick` pulses: `page` goes 0→1 one cycle after the 3rd pulse.
  - `page_next` coincident with that 3rd tick: page advances exactly once and the count restarts.
- **No tearing.** Change ss from 8'h59 to 8'h00 while digit 1 of page 2 is driven. Require the remainder of that frame to show "59" and the next frame to show "00".
- **Invalid BCD.** mm=8'h3C on page 1. Require digit 1 = '3' and digit 0 = 'E' (seg_n=8'h86).
- **Blink and reset mid-frame.**
  - With `CLOCK_DISPLAY_BLINK_EN` defined, `seg_n[7]` on digit 1 toggles on each `sec_tick`.
  - Assert reset mid-DRIVE: all outputs return to their reset values on the next edge.
